// File: rtl/clock_cpu_display.sv
// Digital-clock controller: BCD time of day from a prescaled clock, a
// multiplexed 4-digit 7-segment display with colon, set buttons and a
// brightness PWM. It sits in the same socket as the microcontroller core,
// so the UART/debug pins exist but are inert.

// Per-button synchronizer plus rising-edge detector. One instance per button.
module clock_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);
  // [0],[1] = two-flop synchronizer, [2] = previous synchronized level.
  // The chain presets to all ones so that a button held through reset
  // reads as "already pressed" and cannot produce a spurious edge on release.
  logic [2:0] sync_pipe;

  // Shift the raw button level through the synchronizer.
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_pipe <= '1;
    else     sync_pipe <= {sync_pipe[1:0], btn};

  assign rise = sync_pipe[1] & ~sync_pipe[2];
endmodule

module clock_cpu_display #(
  parameter int SEC_DIV = 1000,  // clk cycles per second tick, even, >= 4
  parameter int MUX_DIV = 16     // clk cycles per displayed digit, >= 1
) (
  input  logic        clk,
  input  logic        reset_in,
  output logic        debug,
  output logic        quit,
  input  logic [15:0] gpi,
  output logic [15:0] gpo,
  output logic        tx,
  input  logic        rx,
  output logic        pwm,
  output logic [6:0]  segments,
  output logic [3:0]  seg_select,
  output logic        seg_colon,
  output logic        seg_dot
);
  localparam int NUM_BTN = 3;
  localparam int PW      = $clog2(SEC_DIV);
  localparam int MW      = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;

  // Time of day, each field two BCD digits.
  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] mn;
    logic [7:0] sc;
  } tod_t;

  tod_t               tod, tod_n;
  logic [PW-1:0]      pre, pre_n;
  logic               tick;
  logic               sec_carry, min_carry;
  logic [MW-1:0]      mux_cnt;
  logic [1:0]         dsel;
  logic [3:0]         dig;
  logic [7:0]         pc;
  logic [NUM_BTN-1:0] btn_rise;

  // Two-digit BCD increment that wraps to 00 after max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max)            r = 8'h00;
    else if (v[3:0] == 4'h9) r = {v[7:4] + 4'd1, 4'h0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // BCD digit to active-high segments, bit0 = a .. bit6 = g.
  function automatic logic [6:0] font(input logic [3:0] d);
    logic [6:0] f;
    case (d)
      4'd0:    f = 7'h3F;
      4'd1:    f = 7'h06;
      4'd2:    f = 7'h5B;
      4'd3:    f = 7'h4F;
      4'd4:    f = 7'h66;
      4'd5:    f = 7'h6D;
      4'd6:    f = 7'h7D;
      4'd7:    f = 7'h07;
      4'd8:    f = 7'h7F;
      4'd9:    f = 7'h6F;
      default: f = 7'h00;
    endcase
    return f;
  endfunction

  clock_btn_sync u_btn [NUM_BTN-1:0] (
    .clk  (clk),
    .rst  (reset_in),
    .btn  (gpi[NUM_BTN-1:0]),
    .rise (btn_rise)
  );

  assign tick      = (pre == PW'(SEC_DIV - 1));
  assign sec_carry = tick && (tod.sc == 8'h59);
  assign min_carry = sec_carry && (tod.mn == 8'h59);

  // Next time/prescaler: tick-driven counting first, then button edges
  // override only the field they touch. Carries are taken from the
  // pre-update values so a button never blocks a carry into another field.
  always_comb begin
    tod_n = tod;
    pre_n = tick ? '0 : pre + PW'(1);
    if (tick)        tod_n.sc = bcd_inc(tod.sc, 8'h59);
    if (sec_carry)   tod_n.mn = bcd_inc(tod.mn, 8'h59);
    if (min_carry)   tod_n.hr = bcd_inc(tod.hr, 8'h23);
    if (btn_rise[0]) tod_n.mn = bcd_inc(tod.mn, 8'h59);
    if (btn_rise[1]) tod_n.hr = bcd_inc(tod.hr, 8'h23);
    if (btn_rise[2]) begin
      tod_n.sc = 8'h00;
      pre_n    = '0;
    end
  end

  // Time-of-day and prescaler registers.
  always_ff @(posedge clk or posedge reset_in)
    if (reset_in) begin
      tod <= '0;
      pre <= '0;
    end else begin
      tod <= tod_n;
      pre <= pre_n;
    end

  // Digit scan: hold each digit for MUX_DIV cycles, then advance 0..3.
  always_ff @(posedge clk or posedge reset_in)
    if (reset_in) begin
      mux_cnt <= '0;
      dsel    <= '0;
    end else if (mux_cnt == MW'(MUX_DIV - 1)) begin
      mux_cnt <= '0;
      dsel    <= dsel + 2'd1;
    end else begin
      mux_cnt <= mux_cnt + MW'(1);
    end

  // Free-running PWM phase counter.
  always_ff @(posedge clk or posedge reset_in)
    if (reset_in) pc <= '0;
    else          pc <= pc + 8'd1;

  // BCD digit shown at the current scan position (3 = hour tens).
  always_comb begin
    dig = 4'h0;
    case (dsel)
      2'd0: dig = tod.mn[3:0];
      2'd1: dig = tod.mn[7:4];
      2'd2: dig = tod.hr[3:0];
      2'd3: dig = tod.hr[7:4];
      default: dig = 4'h0;
    endcase
  end

  // Registered display, status and PWM outputs, all sampled from current state.
  always_ff @(posedge clk or posedge reset_in)
    if (reset_in) begin
      seg_select <= '0;
      segments   <= '0;
      seg_colon  <= 1'b0;
      seg_dot    <= 1'b0;
      debug      <= 1'b0;
      pwm        <= 1'b0;
    end else begin
      seg_select <= 4'b0001 << dsel;
      segments   <= font(dig);
      seg_colon  <= (pre < PW'(SEC_DIV / 2));
      // Dot sits between hours and minutes; blinks with odd seconds.
      seg_dot    <= (dsel == 2'd2) && tod.sc[0];
      debug      <= tick;
      pwm        <= (pc >= gpi[15:8]);
    end

  assign gpo  = {tod.hr, tod.mn};
  assign tx   = 1'b1;
  assign quit = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{rx, gpi[7:NUM_BTN]};
endmodule

// File: tb/tb_clock_cpu_display.sv
// Directed bench for clock_cpu_display with a fast second (SEC_DIV=10).
module tb_clock_cpu_display;
  localparam int SEC_DIV = 10;
  localparam int MUX_DIV = 16;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        debug, quit, tx, rx, pwm, seg_colon, seg_dot;
  logic [15:0] gpi, gpo;
  logic [6:0]  segments;
  logic [3:0]  seg_select;

  clock_cpu_display #(.SEC_DIV(SEC_DIV), .MUX_DIV(MUX_DIV)) dut (
    .clk        (clk),
    .reset_in   (reset_in),
    .debug      (debug),
    .quit       (quit),
    .gpi        (gpi),
    .gpo        (gpo),
    .tx         (tx),
    .rx         (rx),
    .pwm        (pwm),
    .segments   (segments),
    .seg_select (seg_select),
    .seg_colon  (seg_colon),
    .seg_dot    (seg_dot)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;   // rising edges since last reset release

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed %h expected none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic step_to(input int k);
    if (k > cyc) step(k - cyc);
  endtask

  task automatic press(input int b);
    gpi[b] = 1'b1;
    step(3);
    gpi[b] = 1'b0;
    step(3);
  endtask

  task automatic do_reset;
    #2 reset_in = 1'b1;
    step(2);
    reset_in = 1'b0;
    cyc = 0;
  endtask

  function automatic logic [6:0] font7(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          e_cyc, cnt;
    logic [3:0]  sel;
    int          hhmm[4];

    reset_in = 1'b1;
    gpi      = '0;
    rx       = 1'b1;
    step(10);

    // Held in reset.
    push_exp("rst_sel", 0);    chk(seg_select);
    push_exp("rst_seg", 0);    chk(segments);
    push_exp("rst_colon", 0);  chk(seg_colon);
    push_exp("rst_dot", 0);    chk(seg_dot);
    push_exp("rst_gpo", 0);    chk(gpo);
    push_exp("rst_debug", 0);  chk(debug);
    push_exp("rst_pwm", 0);    chk(pwm);
    push_exp("rst_tx", 1);     chk(tx);
    push_exp("rst_quit", 0);   chk(quit);

    // Release cycle still shows reset values.
    reset_in = 1'b0;
    cyc = 0;
    push_exp("rel_sel", 0);    chk(seg_select);

    step(1);
    push_exp("e1_sel", 4'b0001); chk(seg_select);
    push_exp("e1_seg", 7'h3F);   chk(segments);
    push_exp("e1_colon", 1);     chk(seg_colon);
    push_exp("e1_gpo", 0);       chk(gpo);
    push_exp("e1_tx", 1);        chk(tx);
    push_exp("e1_pwm", 1);       chk(pwm);
    push_exp("e1_debug", 0);     chk(debug);

    // Mux scan: one digit step every 16 cycles, all digits 0.
    for (int d = 1; d <= 4; d++) begin
      step(16);
      sel = 4'b0001 << (d % 4);
      push_exp("mux_sel", sel);  chk(seg_select);
      push_exp("mux_seg", 7'h3F); chk(segments);
      // Digit 2 at edge 33 while seconds = 3 (odd).
      if (d == 2) begin push_exp("mux_dot", 1); chk(seg_dot); end
      if (d == 1) begin push_exp("mux_dot0", 0); chk(seg_dot); end
    end

    // debug every 10 cycles; colon 5 high / 5 low.
    for (int k = 66; k <= 85; k++) begin
      step(1);
      push_exp("debug_ph", (k % 10) == 0);      chk(debug);
      push_exp("colon_ph", ((k - 1) % 10) < 5); chk(seg_colon);
    end

    // Minute and hour rollover from ticks alone.
    step_to(599);
    push_exp("min_roll_pre", 16'h0000); chk(gpo);
    step(1);
    push_exp("min_roll", 16'h0001);     chk(gpo);
    push_exp("min_roll_dbg", 1);        chk(debug);
    step_to(35999);
    push_exp("hr_roll_pre", 16'h0059);  chk(gpo);
    step(1);
    push_exp("hr_roll", 16'h0100);      chk(gpo);

    // Asynchronous mid-operation reset with minute button held.
    #2 reset_in = 1'b1;
    gpi[0] = 1'b1;
    #1;
    push_exp("async_gpo", 0);   chk(gpo);
    push_exp("async_sel", 0);   chk(seg_select);
    push_exp("async_seg", 0);   chk(segments);
    push_exp("async_pwm", 0);   chk(pwm);
    step(3);
    reset_in = 1'b0;
    cyc = 0;
    step(10);
    push_exp("held_btn", 16'h0000); chk(gpo);
    gpi[0] = 1'b0;
    step(3);

    // Minute button: 60 presses wrap with no hour carry, 61st gives 01.
    repeat (60) press(0);
    push_exp("min_btn_wrap", 16'h0000); chk(gpo);
    press(0);
    push_exp("min_btn_61", 16'h0001);   chk(gpo);

    // Hour button latency and wrap.
    do_reset();
    step(3);
    gpi[1] = 1'b1;
    push_exp("hr_lat2", 16'h0000);
    push_exp("hr_lat3", 16'h0100);
    step(2); chk(gpo);
    step(1); chk(gpo);
    gpi[1] = 1'b0;
    step(3);
    repeat (22) press(1);
    push_exp("hr_btn_23", 16'h2300); chk(gpo);
    press(1);
    push_exp("hr_btn_24", 16'h0000); chk(gpo);
    press(1);
    push_exp("hr_btn_25", 16'h0100); chk(gpo);

    // Seconds clear mid-second restarts the phase.
    do_reset();
    step_to(34);
    gpi[2] = 1'b1;   // takes effect at edge 37
    for (int k = 35; k <= 60; k++) begin
      step(1);
      if (k == 37) gpi[2] = 1'b0;
      push_exp("sclr_dbg", (k > 37) && ((k - 37) % 10 == 0)); chk(debug);
    end
    step_to(636);
    push_exp("sclr_min_pre", 16'h0000); chk(gpo);
    step(1);
    push_exp("sclr_min", 16'h0001);     chk(gpo);

    // Display contents at 23:59 and midnight rollover.
    do_reset();
    step(3);
    repeat (23) press(1);
    repeat (59) press(0);
    push_exp("set_2359", 16'h2359); chk(gpo);
    e_cyc  = cyc + 3;
    gpi[2] = 1'b1;
    step(3);
    gpi[2] = 1'b0;
    step(3);
    hhmm[3] = 2; hhmm[2] = 3; hhmm[1] = 5; hhmm[0] = 9;
    for (int d = 3; d >= 0; d--) begin
      sel = 4'b0001 << d;
      for (int w = 0; w < 80 && seg_select !== sel; w++) step(1);
      push_exp("disp_sel", sel);           chk(seg_select);
      push_exp("disp_seg", font7(hhmm[d])); chk(segments);
    end
    step_to(e_cyc + 599);
    push_exp("mid_pre", 16'h2359); chk(gpo);
    step(1);
    push_exp("midnight", 16'h0000); chk(gpo);
    push_exp("mid_dbg", 1);         chk(debug);

    // PWM duty.
    gpi[15:8] = 8'h40;
    step(2);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin step(1); cnt += int'(pwm); end
    push_exp("pwm_40", 192); chk(cnt);
    gpi[15:8] = 8'h00;
    step(2);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin step(1); cnt += int'(pwm); end
    push_exp("pwm_00", 256); chk(cnt);
    gpi[15:8] = 8'hFF;
    step(2);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin step(1); cnt += int'(pwm); end
    push_exp("pwm_ff", 1); chk(cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
